rom_sequencer: RTL

//  Timed ROM fetch controller between the ROM and hex_display. It replaces the

---
 rtl/rom_sequencer_if.sv | 24 ++
 rtl/rom_sequencer.sv | 99 +++++++++
 2 files changed

// File: rtl/rom_sequencer_if.sv
// ROM-side and display-side signals of rom_sequencer, bundled for port lists.
// slave is the sequencer's view; master is the surrounding ROM/control/display side.
interface rom_sequencer_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  run;
  logic                  step;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [WIDTH-1:0]      rom_q;
  logic [WIDTH-1:0]      data;
  logic                  data_valid;
  logic                  word_strobe;

  modport slave (
    input  run, step, rom_q,
    output rom_addr, data, data_valid, word_strobe
  );

  modport master (
    output run, step, rom_q,
    input  rom_addr, data, data_valid, word_strobe
  );
endinterface

// File: rtl/rom_sequencer.sv
// Timed ROM fetch controller: fetch a word, capture it after ROM_LATENCY cycles,
// hold it for HOLD_CYCLES (while run=1) or until a step pulse, then advance.
module rom_sequencer #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned LAST_ADDR   = 255,
  parameter int unsigned HOLD_CYCLES = 16777216,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  rom_sequencer_if.slave bus
);
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned LAT_W  = (ROM_LATENCY > 0) ? $clog2(ROM_LATENCY + 1) : 1;

  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(ROM_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(LAST_ADDR);

  typedef enum logic {
    FETCH,
    HOLD
  } state_t;

  state_t                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [WIDTH-1:0]      data_q,     data_d;
  logic                  valid_q,    valid_d;
  logic                  strobe_q,   strobe_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [LAT_W-1:0]      lat_cnt_q,  lat_cnt_d;
  logic                  advance;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    strobe_d   = 1'b0;
    hold_cnt_d = hold_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    advance    = 1'b0;

    case (state_q)
      FETCH: begin
        // run/step deliberately not looked at here: a step during fetch is dropped
        if (lat_cnt_q == LAT_LAST) begin
          data_d     = bus.rom_q;
          valid_d    = 1'b1;
          strobe_d   = 1'b1;
          hold_cnt_d = '0;
          state_d    = HOLD;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        advance = (bus.run && (hold_cnt_q == HOLD_LAST)) || bus.step;
        if (advance) begin
          addr_d     = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
          hold_cnt_d = '0;
          lat_cnt_d  = '0;
          state_d    = FETCH;
        end else if (bus.run) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      addr_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      hold_cnt_q <= '0;
      lat_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
      hold_cnt_q <= hold_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

  assign bus.rom_addr    = addr_q;
  assign bus.data        = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.word_strobe = strobe_q;
endmodule
